// File: rtl/subleq_datapath_if.sv
// Subleq datapath bundle: sequencer strobes, ROM instruction,
// data RAM bus and architectural status.
interface subleq_datapath_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic            selop;
    logic            awe;
    logic            bwe;
    logic            ramwe;
    logic            pcwe;
    logic [3*AW-1:0] instr;
    logic [DW-1:0]   ram_rdata;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata;
    logic            ram_we;
    logic [AW-1:0]   pc;
    logic            leq;
    logic            halted;
    logic [15:0]     retired;

    modport master (
        output selop, awe, bwe, ramwe, pcwe,
        output instr, ram_rdata,
        input  ram_addr, ram_wdata, ram_we,
        input  pc, leq, halted, retired
    );

    modport slave (
        input  selop, awe, bwe, ramwe, pcwe,
        input  instr, ram_rdata,
        output ram_addr, ram_wdata, ram_we,
        output pc, leq, halted, retired
    );
endinterface

// File: rtl/subleq_datapath.sv
// Subleq execution datapath: operand latches, subtract/write-back,
// branch-if-<=0 PC update, sticky halt and retired counter.
module subleq_datapath #(
    parameter int            DW        = 8,
    parameter int            AW        = 8,
    parameter logic [AW-1:0] HALT_ADDR = {AW{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    subleq_datapath_if.slave dp
);
    logic [AW-1:0] fa, fb, fc;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          leq_q, leq_d;
    logic          halted_q, halted_d;
    logic [15:0]   retired_q, retired_d;
    logic [DW-1:0] diff;
    logic          run;

    assign {fa, fb, fc} = dp.instr;
    assign diff = b_q - a_q;
    assign run  = ~halted_q;

    assign dp.ram_addr  = (dp.selop | dp.ramwe) ? fb : fa;
    assign dp.ram_wdata = diff;
    assign dp.ram_we    = dp.ramwe & run;
    assign dp.pc        = pc_q;
    assign dp.leq       = leq_q;
    assign dp.halted    = halted_q;
    assign dp.retired   = retired_q;

    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        leq_d     = leq_q;
        pc_d      = pc_q;
        halted_d  = halted_q;
        retired_d = retired_q;
        if (run) begin
            if (dp.awe) a_d = dp.ram_rdata;
            if (dp.bwe) b_d = dp.ram_rdata;
            if (dp.ramwe) leq_d = (diff == '0) | diff[DW-1];
            // Branch uses the leq latched by the preceding write-back.
            if (dp.pcwe) begin
                if (retired_q != 16'hFFFF) retired_d = retired_q + 16'd1;
                if (leq_q) begin
                    pc_d = fc;
                    if (fc == HALT_ADDR) halted_d = 1'b1;
                end else begin
                    pc_d = pc_q + AW'(3);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            leq_q     <= 1'b0;
            pc_q      <= '0;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            leq_q     <= leq_d;
            pc_q      <= pc_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end
endmodule

// File: tb/tb_subleq_datapath.sv
// Bench for subleq_datapath: drives the four-phase strobes against
// an instruction-level reference model and a bench-owned data RAM.
module tb_subleq_datapath;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    subleq_datapath_if #(.DW(8), .AW(8)) bus ();

    subleq_datapath #(.DW(8), .AW(8)) dut (
        .clk(clk),
        .rst(rst),
        .dp (bus)
    );

    logic [7:0] mem [256];
    logic       ld = 1'b0;
    logic [7:0] ld_a = '0;
    logic [7:0] ld_d = '0;

    assign bus.ram_rdata = mem[bus.ram_addr];

    always @(posedge clk) begin
        if (ld) mem[ld_a] <= ld_d;
        else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    end

    logic [7:0]  mm [256];
    logic [7:0]  m_pc;
    logic        m_leq;
    logic        m_halted;
    logic [15:0] m_retired;
    int n_cmp = 0;
    int n_err = 0;

    task automatic model_reset();
        m_pc = 8'h00;
        m_leq = 1'b0;
        m_halted = 1'b0;
        m_retired = 16'h0000;
    endtask

    task automatic clr_strobes();
        bus.selop = 1'b0;
        bus.awe = 1'b0;
        bus.bwe = 1'b0;
        bus.ramwe = 1'b0;
        bus.pcwe = 1'b0;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        ld = 1'b1;
        ld_a = a;
        ld_d = d;
        mm[a] = d;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic run_instr(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, output logic [7:0] wd);
        logic [7:0] r;
        bus.instr = {a, b, c};
        @(negedge clk);
        bus.awe = 1'b1;
        @(negedge clk);
        bus.awe = 1'b0;
        bus.selop = 1'b1;
        bus.bwe = 1'b1;
        @(negedge clk);
        bus.selop = 1'b0;
        bus.bwe = 1'b0;
        bus.ramwe = 1'b1;
        #1 wd = bus.ram_wdata;
        @(negedge clk);
        bus.ramwe = 1'b0;
        bus.pcwe = 1'b1;
        @(negedge clk);
        bus.pcwe = 1'b0;
        if (!m_halted) begin
            r = mm[b] - mm[a];
            mm[b] = r;
            m_leq = (r == 8'h00) || (r > 8'h7F);
            if (m_retired != 16'hFFFF) m_retired = m_retired + 16'd1;
            if (m_leq) begin
                m_pc = c;
                if (c == 8'hFF) m_halted = 1'b1;
            end else begin
                m_pc = m_pc + 8'd3;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        logic [7:0] wd;
        #1;
        n_cmp++;
        if ({bus.pc, bus.leq, bus.halted, bus.retired} !== 26'h0) begin
            n_err++;
            $display("FAIL por_regs got pc=%h leq=%b h=%b ret=%h want 0",
                     bus.pc, bus.leq, bus.halted, bus.retired);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        load(8'h01, 8'h22);
        load(8'h02, 8'h22);
        run_instr(8'h01, 8'h02, 8'h12, wd);
        n_cmp++;
        if (bus.pc !== m_pc) begin
            n_err++;
            $display("FAIL rst_setup_pc got %h want %h", bus.pc, m_pc);
        end
        load(8'h20, 8'h55);
        bus.instr = {8'h20, 8'h21, 8'h00};
        @(negedge clk);
        bus.awe = 1'b1;
        @(negedge clk);
        bus.awe = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.pc, bus.leq, bus.halted, bus.retired} !== 26'h0) begin
            n_err++;
            $display("FAIL rst_regs got pc=%h leq=%b h=%b ret=%h want 0",
                     bus.pc, bus.leq, bus.halted, bus.retired);
        end
        n_cmp++;
        if (bus.ram_wdata !== 8'h00 || bus.ram_we !== 1'b0) begin
            n_err++;
            $display("FAIL rst_ab got wdata=%h we=%b want 00/0",
                     bus.ram_wdata, bus.ram_we);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        n_cmp++;
        if (bus.ram_we !== 1'b0) begin
            n_err++;
            $display("FAIL rst_nowrite got %b want 0", bus.ram_we);
        end
    endtask

    task automatic test_no_branch();
        logic [7:0] wd;
        load(8'h10, 8'd3);
        load(8'h11, 8'd10);
        run_instr(8'h10, 8'h11, 8'h40, wd);
        n_cmp++;
        if (mem[8'h11] !== 8'd7 || bus.leq !== 1'b0) begin
            n_err++;
            $display("FAIL nb_data got mem=%h leq=%b want 07/0",
                     mem[8'h11], bus.leq);
        end
        n_cmp++;
        if (bus.pc !== 8'h03 || bus.retired !== 16'd1) begin
            n_err++;
            $display("FAIL nb_pc got pc=%h ret=%h want 03/0001",
                     bus.pc, bus.retired);
        end
    endtask

    task automatic test_branch_zero();
        logic [7:0] wd;
        load(8'h12, 8'd5);
        load(8'h13, 8'd5);
        run_instr(8'h12, 8'h13, 8'h40, wd);
        n_cmp++;
        if (mem[8'h13] !== 8'h00 || bus.leq !== 1'b1 || bus.pc !== 8'h40) begin
            n_err++;
            $display("FAIL bz got mem=%h leq=%b pc=%h want 00/1/40",
                     mem[8'h13], bus.leq, bus.pc);
        end
    endtask

    task automatic test_negative_wrap();
        logic [7:0] wd;
        logic [7:0] exp_pc;
        load(8'h50, 8'h01);
        load(8'h51, 8'h80);
        exp_pc = m_pc + 8'd3;
        run_instr(8'h50, 8'h51, 8'h40, wd);
        n_cmp++;
        if (wd !== 8'h7F || bus.leq !== 1'b0 || bus.pc !== exp_pc) begin
            n_err++;
            $display("FAIL neg got wd=%h leq=%b pc=%h want 7f/0/%h",
                     wd, bus.leq, bus.pc, exp_pc);
        end
        load(8'h52, 8'h09);
        load(8'h53, 8'h09);
        run_instr(8'h52, 8'h53, 8'hFE, wd);
        load(8'h54, 8'h01);
        load(8'h55, 8'h05);
        run_instr(8'h54, 8'h55, 8'h40, wd);
        n_cmp++;
        if (bus.pc !== 8'h01) begin
            n_err++;
            $display("FAIL pc_wrap got %h want 01", bus.pc);
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b, c, wd;
        for (int i = 0; i < 24; i++) begin
            a = 8'($urandom_range(0, 255));
            b = (i % 4 == 0) ? a : 8'($urandom_range(0, 255));
            c = 8'($urandom_range(0, 254));
            run_instr(a, b, c, wd);
            n_cmp++;
            if (bus.pc !== m_pc || bus.leq !== m_leq ||
                bus.retired !== m_retired || mem[b] !== mm[b]) begin
                n_err++;
                $display("FAIL rnd%0d got pc=%h leq=%b ret=%h m=%h want %h/%b/%h/%h",
                         i, bus.pc, bus.leq, bus.retired, mem[b],
                         m_pc, m_leq, m_retired, mm[b]);
            end
        end
    endtask

    task automatic test_halt();
        logic [7:0] wd;
        logic [15:0] ret0;
        load(8'h30, 8'h09);
        load(8'h31, 8'h09);
        run_instr(8'h30, 8'h31, 8'hFF, wd);
        n_cmp++;
        if (bus.halted !== 1'b1 || bus.pc !== 8'hFF) begin
            n_err++;
            $display("FAIL halt got h=%b pc=%h want 1/ff", bus.halted, bus.pc);
        end
        ret0 = m_retired;
        load(8'h30, 8'h01);
        load(8'h31, 8'h05);
        bus.instr = {8'h30, 8'h31, 8'h10};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            {bus.selop, bus.awe, bus.bwe, bus.ramwe, bus.pcwe} = 5'b11111;
            #1;
            n_cmp++;
            if (bus.ram_we !== 1'b0) begin
                n_err++;
                $display("FAIL halt_we%0d got %b want 0", i, bus.ram_we);
            end
        end
        @(negedge clk);
        clr_strobes();
        n_cmp++;
        if (bus.pc !== 8'hFF || bus.retired !== ret0 ||
            mem[8'h31] !== 8'h05 || bus.leq !== 1'b1) begin
            n_err++;
            $display("FAIL halt_frozen got pc=%h ret=%h m=%h leq=%b want ff/%h/05/1",
                     bus.pc, bus.retired, mem[8'h31], bus.leq, ret0);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        bus.instr = {8'h00, 8'h00, 8'h00};
        @(negedge clk);
        bus.pcwe = 1'b1;
        repeat (65534) @(negedge clk);
        bus.pcwe = 1'b0;
        m_retired = 16'hFFFE;
        m_pc = 8'((3 * 65534) % 256);
        n_cmp++;
        if (bus.retired !== m_retired || bus.pc !== m_pc) begin
            n_err++;
            $display("FAIL sat_pre got ret=%h pc=%h want %h/%h",
                     bus.retired, bus.pc, m_retired, m_pc);
        end
        for (int i = 0; i < 3; i++) begin
            bus.pcwe = 1'b1;
            @(negedge clk);
            bus.pcwe = 1'b0;
            m_pc = m_pc + 8'd3;
            n_cmp++;
            if (bus.retired !== 16'hFFFF || bus.pc !== m_pc) begin
                n_err++;
                $display("FAIL sat%0d got ret=%h pc=%h want ffff/%h",
                         i, bus.retired, bus.pc, m_pc);
            end
        end
    endtask

    initial begin
        clr_strobes();
        bus.instr = '0;
        model_reset();
        @(negedge clk);
        ld = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ld_a = 8'(i);
            ld_d = 8'($urandom_range(0, 255));
            mm[i] = ld_d;
            @(negedge clk);
        end
        ld = 1'b0;
        test_reset();
        test_no_branch();
        test_branch_zero();
        test_negative_wrap();
        test_random();
        test_halt();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
